// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and strobe/display outputs between the mode controller
// and its neighbours (debouncers, counter bank, display mux).
interface clock_set_ctrl_if;
  logic       sec_tick;
  logic       fast_tick;
  logic       mode_btn;
  logic       up_btn;
  logic       time_run;
  logic       sec_clr;
  logic       hour_inc;
  logic       min_inc;
  logic       ahour_inc;
  logic       amin_inc;
  logic       blink_h;
  logic       blink_m;
  logic       disp_alm;
  logic       alm_on;
  logic [2:0] state;

  modport master (
    output sec_tick, fast_tick, mode_btn, up_btn,
    input  time_run, sec_clr, hour_inc, min_inc, ahour_inc, amin_inc,
           blink_h, blink_m, disp_alm, alm_on, state
  );

  modport slave (
    input  sec_tick, fast_tick, mode_btn, up_btn,
    output time_run, sec_clr, hour_inc, min_inc, ahour_inc, amin_inc,
           blink_h, blink_m, disp_alm, alm_on, state
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the 24-hour clock: button edges to counter strobes,
// auto-repeat, blink and inactivity timeout. Macro CLKSET_ALARM_TOGGLE_EN adds UP-in-RUN alarm toggling.
module clock_set_ctrl #(
  parameter int RPT_DLY    = 5,
  parameter int RPT_PER    = 2,
  parameter int BLINK_HALF = 5,
  parameter int TIMEOUT    = 30
) (
  input  logic            clk,
  input  logic            rst,
  clock_set_ctrl_if.slave bus
);

  localparam int RW = $clog2(RPT_DLY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    ALM_H = 3'd3,
    ALM_M = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic            mode_p0, up_p0;
  logic [RW-1:0]   rpt_cnt, rpt_cnt_n;
  logic            blk, blk_n;
  logic [BW-1:0]   blink_cnt, blink_cnt_n;
  logic            phase, phase_n;
  logic [TW-1:0]   to_cnt, to_cnt_n;
  logic            alm_q, alm_n;

  logic            time_run_q, sec_clr_q, hour_q, min_q, ahour_q, amin_q;
  logic            blink_h_q, blink_m_q, disp_alm_q;

  logic            mode_edge, up_edge, set_st, time_set, timeout_hit, chg;
  logic            rpt_hit, strobe, sec_clr_n;

  always_comb begin
    mode_edge   = bus.mode_btn & ~mode_p0;
    up_edge     = bus.up_btn & ~up_p0;
    set_st      = (state_q == SET_H) || (state_q == SET_M) ||
                  (state_q == ALM_H) || (state_q == ALM_M);
    time_set    = (state_q == SET_H) || (state_q == SET_M);
    timeout_hit = set_st && bus.sec_tick && (to_cnt == TW'(TIMEOUT - 1));

    state_n = state_q;
    case (state_q)
      RUN:     if (mode_edge) state_n = SET_H;
      SET_H:   if (mode_edge) state_n = SET_M;
      SET_M:   if (mode_edge) state_n = ALM_H;
      ALM_H:   if (mode_edge) state_n = ALM_M;
      ALM_M:   if (mode_edge) state_n = RUN;
      default: state_n = RUN;
    endcase
    if (timeout_hit) state_n = RUN;
    chg = (state_n != state_q);

    // A UP level carried across a mode change stays blocked until released.
    rpt_cnt_n = '0;
    rpt_hit   = 1'b0;
    if (set_st && bus.up_btn && !blk && !chg) begin
      rpt_cnt_n = rpt_cnt;
      if (bus.fast_tick) begin
        if (rpt_cnt + 1'b1 == RW'(RPT_DLY)) begin
          rpt_hit   = 1'b1;
          rpt_cnt_n = RW'(RPT_DLY - RPT_PER);
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end
    end
    strobe = set_st && !chg && (up_edge || rpt_hit);

    if (!bus.up_btn)  blk_n = 1'b0;
    else if (chg)     blk_n = 1'b1;
    else              blk_n = blk;

    if (chg || mode_edge || up_edge || rpt_hit || !set_st) to_cnt_n = '0;
    else if (bus.sec_tick)                                 to_cnt_n = to_cnt + 1'b1;
    else                                                   to_cnt_n = to_cnt;

    phase_n     = phase;
    blink_cnt_n = blink_cnt;
    if (strobe || chg) begin
      phase_n     = 1'b0;
      blink_cnt_n = '0;
    end else if (bus.fast_tick) begin
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        phase_n     = ~phase;
        blink_cnt_n = '0;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end

    sec_clr_n = time_set && chg && !((state_n == SET_H) || (state_n == SET_M));

`ifdef CLKSET_ALARM_TOGGLE_EN
    alm_n = alm_q ^ ((state_q == RUN) && up_edge && !mode_edge);
`else
    alm_n = 1'b1;
`endif
  end

  // Registered state, edge history and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      mode_p0   <= 1'b0;
      up_p0     <= 1'b0;
      rpt_cnt   <= '0;
      blk       <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      to_cnt    <= '0;
      alm_q     <= 1'b1;
    end else begin
      state_q   <= state_n;
      mode_p0   <= bus.mode_btn;
      up_p0     <= bus.up_btn;
      rpt_cnt   <= rpt_cnt_n;
      blk       <= blk_n;
      blink_cnt <= blink_cnt_n;
      phase     <= phase_n;
      to_cnt    <= to_cnt_n;
      alm_q     <= alm_n;
    end
  end

  // Registered outputs, all derived from the next-cycle view
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_run_q <= 1'b1;
      sec_clr_q  <= 1'b0;
      hour_q     <= 1'b0;
      min_q      <= 1'b0;
      ahour_q    <= 1'b0;
      amin_q     <= 1'b0;
      blink_h_q  <= 1'b0;
      blink_m_q  <= 1'b0;
      disp_alm_q <= 1'b0;
    end else begin
      time_run_q <= !((state_n == SET_H) || (state_n == SET_M));
      sec_clr_q  <= sec_clr_n;
      hour_q     <= strobe && (state_q == SET_H);
      min_q      <= strobe && (state_q == SET_M);
      ahour_q    <= strobe && (state_q == ALM_H);
      amin_q     <= strobe && (state_q == ALM_M);
      blink_h_q  <= phase_n && ((state_n == SET_H) || (state_n == ALM_H));
      blink_m_q  <= phase_n && ((state_n == SET_M) || (state_n == ALM_M));
      disp_alm_q <= (state_n == ALM_H) || (state_n == ALM_M);
    end
  end

  assign bus.state     = state_q;
  assign bus.time_run  = time_run_q;
  assign bus.sec_clr   = sec_clr_q;
  assign bus.hour_inc  = hour_q;
  assign bus.min_inc   = min_q;
  assign bus.ahour_inc = ahour_q;
  assign bus.amin_inc  = amin_q;
  assign bus.blink_h   = blink_h_q;
  assign bus.blink_m   = blink_m_q;
  assign bus.disp_alm  = disp_alm_q;
  assign bus.alm_on    = alm_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each driven cycle queues the output
// vector expected after the next clock edge; a monitor pops and compares.
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_set_ctrl_if ifc ();

  clock_set_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          hinc_seen = 0;
  logic        exp_alm = 1'b1;
  logic [12:0] exp_q[$];
  logic [12:0] mask_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // {state, time_run, sec_clr, hour, min, ahour, amin, blink_h, blink_m, disp_alm, alm_on}
  function automatic logic [12:0] pack(input logic [2:0] s, input logic clr, input logic [3:0] inc,
                                       input logic bh, input logic bm, input logic alm);
    logic tr, da;
    tr = !((s == 3'd1) || (s == 3'd2));
    da = (s == 3'd3) || (s == 3'd4);
    return {s, tr, clr, inc, bh, bm, da, alm};
  endfunction

  function automatic logic [12:0] observed();
    return {ifc.state, ifc.time_run, ifc.sec_clr, ifc.hour_inc, ifc.min_inc, ifc.ahour_inc,
            ifc.amin_inc, ifc.blink_h, ifc.blink_m, ifc.disp_alm, ifc.alm_on};
  endfunction

  always @(posedge clk) begin
    #1;
    if (ifc.hour_inc) hinc_seen++;
    if (exp_q.size() > 0) begin
      logic [12:0] e, m;
      string       t;
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      check(t, observed() & m, e & m);
    end
  end

  // inc = {hour, min, ahour, amin}; blink compared when bcare or expected state is RUN
  task automatic step(input bit md, input bit up, input bit ft, input bit st,
                      input logic [2:0] ns, input logic [3:0] inc, input bit clr,
                      input bit bcare, input bit bh, input bit bm, input string tag);
    logic [12:0] m;
    ifc.mode_btn  = md;
    ifc.up_btn    = up;
    ifc.fast_tick = ft;
    ifc.sec_tick  = st;
    m = 13'h1fff;
    if (!(bcare || ns == 3'd0)) m[3:2] = 2'b00;
    exp_q.push_back(pack(ns, clr, inc, bh, bm, exp_alm));
    mask_q.push_back(m);
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [2:0] ns, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ns, 4'b0000, 0, 0, 0, 0, tag);
  endtask

  task automatic mode_press(input logic [2:0] ns, input bit clr, input string tag);
    step(1, 0, 0, 0, ns, 4'b0000, clr, 0, 0, 0, tag);
    step(0, 0, 0, 0, ns, 4'b0000, 0, 0, 0, 0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    ifc.mode_btn = 0; ifc.up_btn = 0; ifc.fast_tick = 0; ifc.sec_tick = 0;

    idle(3, 3'd0, "reset");
    rst = 1'b0;
    idle(100, 3'd0, "run_idle");

    // Mode walk and one UP press in ALM_M
    mode_press(3'd1, 0, "to_set_h");
    mode_press(3'd2, 0, "to_set_m");
    mode_press(3'd3, 1, "to_alm_h");
    mode_press(3'd4, 0, "to_alm_m");
    step(0, 1, 0, 0, 3'd4, 4'b0001, 0, 0, 0, 0, "amin_up");
    step(0, 0, 0, 0, 3'd4, 4'b0000, 0, 0, 0, 0, "amin_rel");
    mode_press(3'd0, 0, "alm_m_to_run");

    // SET_H with UP held across 11 fast ticks
    mode_press(3'd1, 0, "hold_enter");
    step(0, 1, 0, 0, 3'd1, 4'b1000, 0, 1, 0, 0, "hold_edge");
    for (int k = 1; k <= 11; k++) begin
      step(0, 1, 1, 0, 3'd1, (k >= 5 && (k % 2) == 1) ? 4'b1000 : 4'b0000, 0, 1, 0, 0,
           $sformatf("hold_tick%0d", k));
      step(0, 1, 0, 0, 3'd1, 4'b0000, 0, 1, 0, 0, $sformatf("hold_gap%0d", k));
    end
    step(0, 0, 0, 0, 3'd1, 4'b0000, 0, 1, 0, 0, "hold_rel");

    // SET_M inactivity timeout
    mode_press(3'd2, 0, "to_enter");
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0, 1, (k == 30) ? 3'd0 : 3'd2, 4'b0000, k == 30, 0, 0, 0,
           $sformatf("to_tick%0d", k));
      step(0, 0, 0, 0, (k == 30) ? 3'd0 : 3'd2, 4'b0000, 0, 0, 0, 0,
           $sformatf("to_gap%0d", k));
    end

    // MODE and UP together in SET_H, then UP held in SET_M
    mode_press(3'd1, 0, "both_enter");
    step(1, 1, 0, 0, 3'd2, 4'b0000, 0, 1, 0, 0, "both_edge");
    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 1, 0, 3'd2, 4'b0000, 0, 1, 0, ((k / 5) % 2) == 1, $sformatf("blk_tick%0d", k));
      step(0, 1, 0, 0, 3'd2, 4'b0000, 0, 1, 0, ((k / 5) % 2) == 1, $sformatf("blk_gap%0d", k));
    end
    step(0, 0, 0, 0, 3'd2, 4'b0000, 0, 1, 0, 0, "blk_rel");
    mode_press(3'd3, 1, "blk_to_alm_h");
    mode_press(3'd4, 0, "blk_to_alm_m");
    mode_press(3'd0, 0, "blk_to_run");

    // Reset while setting: back to RUN without SEC_CLR
    mode_press(3'd1, 0, "rmid_enter");
    rst = 1'b1;
    step(0, 0, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, "rmid_reset");
    rst = 1'b0;
    idle(2, 3'd0, "rmid_after");

    // UP presses in RUN
`ifdef CLKSET_ALARM_TOGGLE_EN
    exp_alm = 1'b0;
`endif
    step(0, 1, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, "alm_up1");
    step(0, 0, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, "alm_rel1");
    exp_alm = 1'b1;
    step(0, 1, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, "alm_up2");
    step(0, 0, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, "alm_rel2");
    idle(2, 3'd0, "tail");

    check("hour_inc_total", 13'(hinc_seen), 13'd5);
    check("sb_drained", 13'(exp_q.size()), 13'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
